// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation select and controller states.
// Latency: n/a (types only).
// Backpressure: n/a.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } alu_state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator pair.
// Latency: WIDTH step cycles after load; result valid once last_step has been taken.
// Backpressure: none; the controller owns load/step sequencing.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  alu_op_e          mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last_step,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // acc_hi: MUL upper product half / DIV partial remainder (one spare bit for DIV shift).
  // acc_lo: MUL multiplier shifting out, product low half shifting in / DIV dividend -> quotient.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_diff;

  // One step of each algorithm, computed from the current working registers.
  always_comb begin
    mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
  end

  // Working registers: load operands, then advance one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= (mode == ALU_DIV) ? op_a : op_b;
      opnd   <= (mode == ALU_DIV) ? op_b : op_a;
      is_div <= (mode == ALU_DIV);
      cnt    <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc_hi <= div_ge ? div_diff : div_shift;
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= {1'b0, mul_sum[WIDTH:1]};
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  assign last_step = step && (cnt == LAST_CNT);
  // Both modes leave the answer in acc_lo; only MUL reports overflow from the upper half.
  assign result    = acc_lo;
  assign overflow  = !is_div && (|acc_hi[WIDTH-1:0]);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/DIV-by-zero, iterative MUL/DIV with start/done handshake.
// Latency: 1 cycle for ADD/SUB/DIV-by-zero, WIDTH+2 cycles for MUL/DIV.
// Backpressure: busy high while iterating; start is dropped (not queued) unless in IDLE.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  alu_state_e       state;
  alu_op_e          op;
  logic             accept;
  logic             b_is_zero;
  logic             md_load;
  logic             md_step;
  logic             md_last;
  logic [WIDTH-1:0] md_result;
  logic             md_ovf;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;

  // Decode the request and the single-cycle arithmetic paths.
  always_comb begin
    op        = alu_op_e'(alu_sel);
    accept    = (state == IDLE) && start;
    b_is_zero = (op_b == '0);
    md_load   = accept && ((op == ALU_MUL) || ((op == ALU_DIV) && !b_is_zero));
    md_step   = (state == ITER);
    add_sum   = {1'b0, op_a} + {1'b0, op_b};
    sub_diff  = op_a - op_b;
  end

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (md_load),
    .step      (md_step),
    .mode      (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .last_step (md_last),
    .result    (md_result),
    .overflow  (md_ovf)
  );

  // Controller FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_out     <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              ALU_ADD: begin
                alu_out     <= add_sum[WIDTH-1:0];
                carry       <= add_sum[WIDTH];
                zero        <= (add_sum[WIDTH-1:0] == '0);
                div_by_zero <= 1'b0;
                done        <= 1'b1;
              end
              ALU_SUB: begin
                alu_out     <= sub_diff;
                carry       <= (op_a < op_b);
                zero        <= (sub_diff == '0);
                div_by_zero <= 1'b0;
                done        <= 1'b1;
              end
              ALU_MUL: begin
                state <= ITER;
                busy  <= 1'b1;
              end
              default: begin
                if (b_is_zero) begin
                  alu_out     <= '1;
                  carry       <= 1'b0;
                  zero        <= 1'b0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                end else begin
                  state <= ITER;
                  busy  <= 1'b1;
                end
              end
            endcase
          end
        end
        ITER: begin
          if (md_last) state <= FINISH;
        end
        FINISH: begin
          alu_out     <= md_result;
          carry       <= md_ovf;
          zero        <= (md_result == '0);
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
